// File: rtl/echo_distance_calc.sv
// Ultrasonic echo timer: echo high time (us) -> distance (mm) -> 4-digit packed BCD, with one-cycle valid/timeout strobes.
// Optional ECHO_AVG4_EN: running average of the last four distances (adds one AVG cycle of latency).
module echo_distance_calc #(
    parameter int CLK_MHZ    = 50,
    parameter int TIMEOUT_US = 30000,
    parameter int K_MM       = 11239
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        echo,
    output logic [15:0] dist_bcd,
    output logic        dist_valid,
    output logic        timeout,
    output logic        busy
);
    localparam int PW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MEASURE  = 3'd1;
    localparam logic [2:0] S_WAIT_LOW = 3'd2;
    localparam logic [2:0] S_CALC     = 3'd3;
    localparam logic [2:0] S_CONV     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
`ifdef ECHO_AVG4_EN
    localparam logic [2:0] S_AVG      = 3'd6;
`endif

    logic [2:0]    r_state;
    logic          r_sync1;
    logic          r_echo_s;
    logic          r_echo_d;
    logic [PW-1:0] r_presc;
    logic [14:0]   r_us_cnt;
    logic [29:0]   r_dd;
    logic [3:0]    r_bit_cnt;
    logic [15:0]   r_dist_bcd;
    logic          r_dist_valid;
    logic          r_timeout;
`ifdef ECHO_AVG4_EN
    logic [13:0]   r_buf [4];
    logic [15:0]   w_sum;
    logic [13:0]   w_avg;
`endif

    logic          w_rise;
    logic          w_fall;
    logic [15:0]   w_mm_full;
    logic [13:0]   w_mm;
    logic [29:0]   w_adj;
    logic [29:0]   w_shift;

    assign w_rise = r_echo_s & ~r_echo_d;
    assign w_fall = ~r_echo_s & r_echo_d;

    // us_cnt is bounded by TIMEOUT_US, so the product always fits in 32 bits
    assign w_mm_full = 16'((32'(r_us_cnt) * 32'(K_MM)) >> 16);
    assign w_mm      = (w_mm_full > 16'd9999) ? 14'd9999 : w_mm_full[13:0];

`ifdef ECHO_AVG4_EN
    assign w_sum = 16'(r_buf[0]) + 16'(r_buf[1]) + 16'(r_buf[2]) + 16'(r_buf[3]);
    assign w_avg = 14'(w_sum >> 2);
`endif

    always_comb begin
        w_adj = r_dd;
        for (int n = 0; n < 4; n++) begin
            if (r_dd[14+4*n +: 4] >= 4'd5) begin
                w_adj[14+4*n +: 4] = r_dd[14+4*n +: 4] + 4'd3;
            end
        end
    end
    assign w_shift = w_adj << 1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b0;
            r_echo_s     <= 1'b0;
            r_echo_d     <= 1'b0;
            r_presc      <= '0;
            r_us_cnt     <= '0;
            r_dd         <= '0;
            r_bit_cnt    <= '0;
            r_dist_bcd   <= '0;
            r_dist_valid <= 1'b0;
            r_timeout    <= 1'b0;
`ifdef ECHO_AVG4_EN
            for (int i = 0; i < 4; i++) r_buf[i] <= '0;
`endif
        end else begin
            r_sync1      <= echo;
            r_echo_s     <= r_sync1;
            r_echo_d     <= r_echo_s;
            r_dist_valid <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_presc  <= '0;
                        r_us_cnt <= '0;
                        r_state  <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    // counters freeze on fall so CALC sees the count from the fall cycle
                    if (w_fall) begin
                        r_state <= S_CALC;
                    end else if (r_us_cnt == 15'(TIMEOUT_US)) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_WAIT_LOW;
                    end else if (r_presc == PW'(CLK_MHZ - 1)) begin
                        r_presc  <= '0;
                        r_us_cnt <= r_us_cnt + 15'd1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                S_WAIT_LOW: begin
                    if (!r_echo_s) r_state <= S_IDLE;
                end
                S_CALC: begin
`ifdef ECHO_AVG4_EN
                    r_buf[0] <= w_mm;
                    r_buf[1] <= r_buf[0];
                    r_buf[2] <= r_buf[1];
                    r_buf[3] <= r_buf[2];
                    r_state  <= S_AVG;
`else
                    r_dd      <= {16'd0, w_mm};
                    r_bit_cnt <= '0;
                    r_state   <= S_CONV;
`endif
                end
`ifdef ECHO_AVG4_EN
                S_AVG: begin
                    r_dd      <= {16'd0, w_avg};
                    r_bit_cnt <= '0;
                    r_state   <= S_CONV;
                end
`endif
                S_CONV: begin
                    r_dd      <= w_shift;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd13) begin
                        r_dist_bcd   <= w_shift[29:14];
                        r_dist_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dist_bcd   = r_dist_bcd;
    assign dist_valid = r_dist_valid;
    assign timeout    = r_timeout;
    assign busy       = (r_state != S_IDLE);

endmodule
